riscv_core_reorder_buffer: RTL and testbench

RISCV_CORE_REORDER_BUFFER -- requirements
Module: riscv_core_reorder_buffer

---
 rtl/riscv_core_reorder_buffer_if.sv | 58 +++++
 rtl/riscv_core_reorder_buffer.sv | 131 +++++++++++++
 tb/tb_riscv_core_reorder_buffer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_reorder_buffer_if
// Description : Allocation, writeback-fill and commit bundle for the
//               32-entry reorder buffer.
//               master : issue/writeback side (drives alloc requests, fills)
//               slave  : reorder buffer (drives rdy, granted slots, commits)
// Signals     : rob_alloc_req0/1, rob_alloc_wen0/1, rob_alloc_waddr0/1
//               rob_alloc_rdy, rob_alloc_slot0/1
//               rob_fill_valA/slotA, rob_fill_valB/slotB
//               rob_commit_{val,slot,wen,waddr}_{1,2}, rob_count
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_core_reorder_buffer_if;
  logic       rob_alloc_req0;
  logic       rob_alloc_req1;
  logic       rob_alloc_wen0;
  logic [4:0] rob_alloc_waddr0;
  logic       rob_alloc_wen1;
  logic [4:0] rob_alloc_waddr1;
  logic       rob_alloc_rdy;
  logic [4:0] rob_alloc_slot0;
  logic [4:0] rob_alloc_slot1;
  logic       rob_fill_valA;
  logic [4:0] rob_fill_slotA;
  logic       rob_fill_valB;
  logic [4:0] rob_fill_slotB;
  logic       rob_commit_val_1;
  logic [4:0] rob_commit_slot_1;
  logic       rob_commit_wen_1;
  logic [4:0] rob_commit_waddr_1;
  logic       rob_commit_val_2;
  logic [4:0] rob_commit_slot_2;
  logic       rob_commit_wen_2;
  logic [4:0] rob_commit_waddr_2;
  logic [5:0] rob_count;

  modport master (
    output rob_alloc_req0, rob_alloc_req1,
    output rob_alloc_wen0, rob_alloc_waddr0, rob_alloc_wen1, rob_alloc_waddr1,
    output rob_fill_valA, rob_fill_slotA, rob_fill_valB, rob_fill_slotB,
    input  rob_alloc_rdy, rob_alloc_slot0, rob_alloc_slot1,
    input  rob_commit_val_1, rob_commit_slot_1, rob_commit_wen_1, rob_commit_waddr_1,
    input  rob_commit_val_2, rob_commit_slot_2, rob_commit_wen_2, rob_commit_waddr_2,
    input  rob_count
  );

  modport slave (
    input  rob_alloc_req0, rob_alloc_req1,
    input  rob_alloc_wen0, rob_alloc_waddr0, rob_alloc_wen1, rob_alloc_waddr1,
    input  rob_fill_valA, rob_fill_slotA, rob_fill_valB, rob_fill_slotB,
    output rob_alloc_rdy, rob_alloc_slot0, rob_alloc_slot1,
    output rob_commit_val_1, rob_commit_slot_1, rob_commit_wen_1, rob_commit_waddr_1,
    output rob_commit_val_2, rob_commit_slot_2, rob_commit_wen_2, rob_commit_waddr_2,
    output rob_count
  );
endinterface
`default_nettype wire

// File: rtl/riscv_core_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_reorder_buffer
// Description : 32-entry in-order retirement buffer. Dual allocation per
//               cycle at the tail, two writeback fill ports, in-order commit
//               from the head.
// Ports       : clk   - sole clock, rising edge
//               reset - synchronous active-high reset
//               rob   - riscv_core_reorder_buffer_if.slave (alloc/fill/commit)
// Config      : RISCV_ROB_DUAL_COMMIT_EN - defined: up to two commits per
//               cycle; undefined: single commit, second commit port tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_core_reorder_buffer (
  input wire clk,
  input wire reset,
  riscv_core_reorder_buffer_if.slave rob
);

  localparam int DEPTH = 32;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] r_wen;
  logic [4:0]       r_waddr [DEPTH];
  logic [4:0]       r_head;
  logic [4:0]       r_tail;
  logic [5:0]       r_count;

  logic [4:0] w_head1;
  logic [4:0] w_tail1;
  logic       w_rdy;
  logic       w_alloc0;
  logic       w_alloc1;
  logic       w_commit1;
  logic       w_commit2;
  logic [5:0] w_n_alloc;
  logic [5:0] w_n_commit;

  assign w_head1 = r_head + 5'd1;
  assign w_tail1 = r_tail + 5'd1;

  // Two free entries are always reserved so a pair can be accepted blindly.
  assign w_rdy    = (r_count <= 6'd30);
  assign w_alloc0 = w_rdy & rob.rob_alloc_req0;
  assign w_alloc1 = w_alloc0 & rob.rob_alloc_req1;

  // The count guard keeps stale entry contents from retiring when empty.
  assign w_commit1 = (r_count != 6'd0) & r_valid[r_head] & ~r_pending[r_head];

`ifdef RISCV_ROB_DUAL_COMMIT_EN
  assign w_commit2 = w_commit1 & r_valid[w_head1] & ~r_pending[w_head1];
`else
  assign w_commit2 = 1'b0;
`endif

  assign w_n_alloc  = {5'd0, w_alloc0} + {5'd0, w_alloc1};
  assign w_n_commit = {5'd0, w_commit1} + {5'd0, w_commit2};

  // Control state: valid/pending bits and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= '0;
      r_pending <= '0;
      r_head    <= 5'd0;
      r_tail    <= 5'd0;
      r_count   <= 6'd0;
    end else begin
      // Fills to entries that are not in flight are dropped; a double fill
      // of one slot is harmless since both just clear the same bit.
      if (rob.rob_fill_valA && r_valid[rob.rob_fill_slotA])
        r_pending[rob.rob_fill_slotA] <= 1'b0;
      if (rob.rob_fill_valB && r_valid[rob.rob_fill_slotB])
        r_pending[rob.rob_fill_slotB] <= 1'b0;

      if (w_commit1) r_valid[r_head]  <= 1'b0;
      if (w_commit2) r_valid[w_head1] <= 1'b0;

      // Allocation only targets free entries (count <= 30), so it can never
      // collide with the retiring head entries or a legal fill target.
      if (w_alloc0) begin
        r_valid[r_tail]   <= 1'b1;
        r_pending[r_tail] <= 1'b1;
      end
      if (w_alloc1) begin
        r_valid[w_tail1]   <= 1'b1;
        r_pending[w_tail1] <= 1'b1;
      end

      r_head  <= r_head + w_n_commit[4:0];
      r_tail  <= r_tail + w_n_alloc[4:0];
      r_count <= r_count + w_n_alloc - w_n_commit;
    end
  end

  // Destination payload; only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    if (w_alloc0) begin
      r_wen[r_tail]   <= rob.rob_alloc_wen0;
      r_waddr[r_tail] <= rob.rob_alloc_waddr0;
    end
    if (w_alloc1) begin
      r_wen[w_tail1]   <= rob.rob_alloc_wen1;
      r_waddr[w_tail1] <= rob.rob_alloc_waddr1;
    end
  end

  assign rob.rob_alloc_rdy   = w_rdy;
  assign rob.rob_alloc_slot0 = r_tail;
  assign rob.rob_alloc_slot1 = w_tail1;
  assign rob.rob_count       = r_count;

  assign rob.rob_commit_val_1   = w_commit1;
  assign rob.rob_commit_slot_1  = r_head;
  assign rob.rob_commit_wen_1   = w_commit1 & r_wen[r_head];
  assign rob.rob_commit_waddr_1 = w_commit1 ? r_waddr[r_head] : 5'd0;

`ifdef RISCV_ROB_DUAL_COMMIT_EN
  assign rob.rob_commit_val_2   = w_commit2;
  assign rob.rob_commit_slot_2  = w_head1;
  assign rob.rob_commit_wen_2   = w_commit2 & r_wen[w_head1];
  assign rob.rob_commit_waddr_2 = w_commit2 ? r_waddr[w_head1] : 5'd0;
`else
  assign rob.rob_commit_val_2   = 1'b0;
  assign rob.rob_commit_slot_2  = 5'd0;
  assign rob.rob_commit_wen_2   = 1'b0;
  assign rob.rob_commit_waddr_2 = 5'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_core_reorder_buffer
// Description : Directed self-checking bench for riscv_core_reorder_buffer.
//               Expectations follow RISCV_ROB_DUAL_COMMIT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_core_reorder_buffer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  riscv_core_reorder_buffer_if rob_bus ();

  riscv_core_reorder_buffer dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rob_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rob_bus.rob_alloc_req0   = 1'b0;
    rob_bus.rob_alloc_req1   = 1'b0;
    rob_bus.rob_fill_valA    = 1'b0;
    rob_bus.rob_fill_valB    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    rob_bus.rob_alloc_wen0   = 1'b0;
    rob_bus.rob_alloc_waddr0 = 5'd0;
    rob_bus.rob_alloc_wen1   = 1'b0;
    rob_bus.rob_alloc_waddr1 = 5'd0;
    rob_bus.rob_fill_slotA   = 5'd0;
    rob_bus.rob_fill_slotB   = 5'd0;

    // ---- Reset state ----
    tick();
    chk("rst_rdy",   rob_bus.rob_alloc_rdy, 1);
    chk("rst_count", rob_bus.rob_count, 0);
    chk("rst_slot0", rob_bus.rob_alloc_slot0, 0);
    chk("rst_slot1", rob_bus.rob_alloc_slot1, 1);
    chk("rst_val1",  rob_bus.rob_commit_val_1, 0);
    chk("rst_wen1",  rob_bus.rob_commit_wen_1, 0);
    chk("rst_val2",  rob_bus.rob_commit_val_2, 0);
    chk("rst_wen2",  rob_bus.rob_commit_wen_2, 0);
    reset = 1'b0;
    tick();

    // ---- Pair allocation, waddr 5/6 ----
    rob_bus.rob_alloc_req0 = 1'b1; rob_bus.rob_alloc_wen0 = 1'b1; rob_bus.rob_alloc_waddr0 = 5'd5;
    rob_bus.rob_alloc_req1 = 1'b1; rob_bus.rob_alloc_wen1 = 1'b1; rob_bus.rob_alloc_waddr1 = 5'd6;
    chk("pair_slot0", rob_bus.rob_alloc_slot0, 0);
    chk("pair_slot1", rob_bus.rob_alloc_slot1, 1);
    tick();
    idle_inputs();
    chk("pair_count", rob_bus.rob_count, 2);
    chk("pair_val1",  rob_bus.rob_commit_val_1, 0);
    chk("pair_tail",  rob_bus.rob_alloc_slot0, 2);

    // ---- Out-of-order fill: slot 1 first, then slot 0 ----
    rob_bus.rob_fill_valA = 1'b1; rob_bus.rob_fill_slotA = 5'd1;
    tick();
    idle_inputs();
    chk("ooo_blocked_val1", rob_bus.rob_commit_val_1, 0);
    chk("ooo_blocked_val2", rob_bus.rob_commit_val_2, 0);
    rob_bus.rob_fill_valB = 1'b1; rob_bus.rob_fill_slotB = 5'd0;
    tick();
    idle_inputs();
    chk("ooo_val1",   rob_bus.rob_commit_val_1, 1);
    chk("ooo_slot1",  rob_bus.rob_commit_slot_1, 0);
    chk("ooo_waddr1", rob_bus.rob_commit_waddr_1, 5);
    chk("ooo_wen1",   rob_bus.rob_commit_wen_1, 1);
`ifdef RISCV_ROB_DUAL_COMMIT_EN
    chk("ooo_val2",   rob_bus.rob_commit_val_2, 1);
    chk("ooo_slot2",  rob_bus.rob_commit_slot_2, 1);
    chk("ooo_waddr2", rob_bus.rob_commit_waddr_2, 6);
    tick();
    chk("ooo_drain_count", rob_bus.rob_count, 0);
    chk("ooo_drain_val1",  rob_bus.rob_commit_val_1, 0);
`else
    chk("ooo_val2",   rob_bus.rob_commit_val_2, 0);
    tick();
    chk("ooo_second_count", rob_bus.rob_count, 1);
    chk("ooo_second_val1",  rob_bus.rob_commit_val_1, 1);
    chk("ooo_second_slot1", rob_bus.rob_commit_slot_1, 1);
    chk("ooo_second_waddr", rob_bus.rob_commit_waddr_1, 6);
    tick();
    chk("ooo_drain_count", rob_bus.rob_count, 0);
    chk("ooo_drain_val1",  rob_bus.rob_commit_val_1, 0);
`endif
    // head = tail = 2 here

    // ---- Fill to 31 entries (wen=0), overflow drop, one commit ----
    rob_bus.rob_alloc_req0 = 1'b1; rob_bus.rob_alloc_wen0 = 1'b0; rob_bus.rob_alloc_waddr0 = 5'd7;
    rob_bus.rob_alloc_req1 = 1'b1; rob_bus.rob_alloc_wen1 = 1'b0; rob_bus.rob_alloc_waddr1 = 5'd8;
    for (int i = 0; i < 15; i++) tick();
    rob_bus.rob_alloc_req1 = 1'b0;
    chk("fill30_count", rob_bus.rob_count, 30);
    chk("fill30_rdy",   rob_bus.rob_alloc_rdy, 1);
    tick();
    chk("fill31_count", rob_bus.rob_count, 31);
    chk("fill31_rdy",   rob_bus.rob_alloc_rdy, 0);
    chk("fill31_tail",  rob_bus.rob_alloc_slot0, 1);
    tick();  // req0 still high but must be dropped
    idle_inputs();
    chk("drop_count", rob_bus.rob_count, 31);
    chk("drop_tail",  rob_bus.rob_alloc_slot0, 1);
    rob_bus.rob_fill_valA = 1'b1; rob_bus.rob_fill_slotA = 5'd2;
    tick();
    idle_inputs();
    chk("full_commit_val1",  rob_bus.rob_commit_val_1, 1);
    chk("full_commit_slot1", rob_bus.rob_commit_slot_1, 2);
    chk("full_commit_wen1",  rob_bus.rob_commit_wen_1, 0);
    chk("full_commit_val2",  rob_bus.rob_commit_val_2, 0);
    tick();
    chk("after_commit_count", rob_bus.rob_count, 30);
    chk("after_commit_rdy",   rob_bus.rob_alloc_rdy, 1);

    // ---- Same-cycle commit and pair alloc at count 30 ----
    rob_bus.rob_fill_valA = 1'b1; rob_bus.rob_fill_slotA = 5'd3;
    rob_bus.rob_fill_valB = 1'b1; rob_bus.rob_fill_slotB = 5'd4;
    tick();
    idle_inputs();
    chk("mix_val1",  rob_bus.rob_commit_val_1, 1);
    chk("mix_slot1", rob_bus.rob_commit_slot_1, 3);
    rob_bus.rob_alloc_req0 = 1'b1; rob_bus.rob_alloc_wen0 = 1'b1; rob_bus.rob_alloc_waddr0 = 5'd11;
    rob_bus.rob_alloc_req1 = 1'b1; rob_bus.rob_alloc_wen1 = 1'b1; rob_bus.rob_alloc_waddr1 = 5'd12;
    chk("mix_slot0", rob_bus.rob_alloc_slot0, 1);
`ifdef RISCV_ROB_DUAL_COMMIT_EN
    chk("mix_val2",  rob_bus.rob_commit_val_2, 1);
    chk("mix_slot2", rob_bus.rob_commit_slot_2, 4);
    tick();
    idle_inputs();
    chk("mix_count", rob_bus.rob_count, 30);
    chk("mix_rdy",   rob_bus.rob_alloc_rdy, 1);
    chk("mix_head_val1", rob_bus.rob_commit_val_1, 0);
`else
    chk("mix_val2",  rob_bus.rob_commit_val_2, 0);
    tick();
    idle_inputs();
    chk("mix_count", rob_bus.rob_count, 31);
    chk("mix_rdy",   rob_bus.rob_alloc_rdy, 0);
    chk("mix_next_val1",  rob_bus.rob_commit_val_1, 1);
    chk("mix_next_slot1", rob_bus.rob_commit_slot_1, 4);
`endif
    chk("mix_tail", rob_bus.rob_alloc_slot0, 3);

    // ---- Reset mid-operation with a fill in the reset cycle ----
    reset = 1'b1;
    rob_bus.rob_fill_valA = 1'b1; rob_bus.rob_fill_slotA = 5'd3;
    tick();
    reset = 1'b0;
    idle_inputs();
    chk("mrst_count", rob_bus.rob_count, 0);
    chk("mrst_val1",  rob_bus.rob_commit_val_1, 0);
    chk("mrst_val2",  rob_bus.rob_commit_val_2, 0);
    chk("mrst_rdy",   rob_bus.rob_alloc_rdy, 1);
    chk("mrst_slot0", rob_bus.rob_alloc_slot0, 0);
    chk("mrst_slot1", rob_bus.rob_alloc_slot1, 1);
    tick();
    chk("mrst_idle_val1",  rob_bus.rob_commit_val_1, 0);
    chk("mrst_idle_count", rob_bus.rob_count, 0);

    // ---- Stream 31 single entries through to move head/tail to 31 ----
    rob_bus.rob_alloc_wen0 = 1'b1;
    for (int i = 0; i < 31; i++) begin
      rob_bus.rob_alloc_req0   = 1'b1;
      rob_bus.rob_alloc_waddr0 = 5'(i);
      rob_bus.rob_fill_valA    = (i > 0);
      rob_bus.rob_fill_slotA   = 5'(i - 1);
      tick();
    end
    idle_inputs();
    rob_bus.rob_fill_valA = 1'b1; rob_bus.rob_fill_slotA = 5'd30;
    tick();
    idle_inputs();
    tick();
    chk("stream_count", rob_bus.rob_count, 0);
    chk("stream_slot0", rob_bus.rob_alloc_slot0, 31);
    chk("stream_slot1", rob_bus.rob_alloc_slot1, 0);
    chk("stream_val1",  rob_bus.rob_commit_val_1, 0);

    // ---- Wrap: pair at 31/0 ----
    rob_bus.rob_alloc_req0 = 1'b1; rob_bus.rob_alloc_wen0 = 1'b1; rob_bus.rob_alloc_waddr0 = 5'd9;
    rob_bus.rob_alloc_req1 = 1'b1; rob_bus.rob_alloc_wen1 = 1'b1; rob_bus.rob_alloc_waddr1 = 5'd10;
    tick();
    idle_inputs();
    chk("wrap_count", rob_bus.rob_count, 2);
    chk("wrap_tail",  rob_bus.rob_alloc_slot0, 1);
    rob_bus.rob_fill_valA = 1'b1; rob_bus.rob_fill_slotA = 5'd31;
    rob_bus.rob_fill_valB = 1'b1; rob_bus.rob_fill_slotB = 5'd0;
    tick();
    idle_inputs();
    chk("wrap_val1",   rob_bus.rob_commit_val_1, 1);
    chk("wrap_slot1",  rob_bus.rob_commit_slot_1, 31);
    chk("wrap_waddr1", rob_bus.rob_commit_waddr_1, 9);
    chk("wrap_wen1",   rob_bus.rob_commit_wen_1, 1);
`ifdef RISCV_ROB_DUAL_COMMIT_EN
    chk("wrap_val2",   rob_bus.rob_commit_val_2, 1);
    chk("wrap_slot2",  rob_bus.rob_commit_slot_2, 0);
    chk("wrap_waddr2", rob_bus.rob_commit_waddr_2, 10);
    tick();
`else
    chk("wrap_val2",   rob_bus.rob_commit_val_2, 0);
    tick();
    chk("wrap_second_val1",  rob_bus.rob_commit_val_1, 1);
    chk("wrap_second_slot1", rob_bus.rob_commit_slot_1, 0);
    chk("wrap_second_waddr", rob_bus.rob_commit_waddr_1, 10);
    chk("wrap_second_count", rob_bus.rob_count, 1);
    tick();
`endif
    chk("wrap_end_count", rob_bus.rob_count, 0);
    chk("wrap_end_val1",  rob_bus.rob_commit_val_1, 0);

    // ---- Fill to an invalid slot is ignored ----
    rob_bus.rob_fill_valA = 1'b1; rob_bus.rob_fill_slotA = 5'd1;
    tick();
    idle_inputs();
    rob_bus.rob_alloc_req0 = 1'b1; rob_bus.rob_alloc_waddr0 = 5'd13;
    chk("stale_slot0", rob_bus.rob_alloc_slot0, 1);
    tick();
    idle_inputs();
    chk("stale_count", rob_bus.rob_count, 1);
    chk("stale_val1",  rob_bus.rob_commit_val_1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
